// File: rtl/shift_add_mult_nb.sv
// Sequential unsigned shift-and-add multiplier: one partial product per cycle
// through a single ripple-carry adder, N RUN cycles, one DONE cycle.

module parallel_adder_nb #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o
);
    logic [W:0] carry;

    assign carry[0] = c_i;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
            assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign c_o = carry[W];
endmodule

module shift_add_mult_nb #(
    parameter int N = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [N-1:0]   i_op_a,
    input  logic [N-1:0]   i_op_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_product,
    output logic           o_overflow
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     acc_hi_q, acc_hi_d;
    logic [N-1:0]     acc_lo_q, acc_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [N-1:0]     addend;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic [2*N-1:0]   acc_shifted;

    // The low accumulator half doubles as the multiplier shift register.
    assign addend = acc_lo_q[0] ? mcand_q : '0;

    parallel_adder_nb #(
        .W (N)
    ) u_adder (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .c_i   (1'b0),
        .sum_o (add_sum),
        .c_o   (add_cout)
    );

    // Carry-out lands in the top bit so a final-iteration carry is kept.
    assign acc_shifted = {add_cout, add_sum, acc_lo_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mcand_d  = i_op_a;
                    acc_lo_d = i_op_b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_hi_d = acc_shifted[2*N-1:N];
                acc_lo_d = acc_shifted[N-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d   = ST_DONE;
                    product_d = acc_shifted;
                    ovf_d     = |acc_shifted[2*N-1:N];
                    done_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_product  = product_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_shift_add_mult_nb.sv
// Directed bench for shift_add_mult_nb: latency, corner operands, ignored
// starts, reset abort and continuous back-to-back operation.

module tb_shift_add_mult_nb;
    localparam int N = 16;

    logic           i_clk;
    logic           i_rst_n;
    logic           i_start;
    logic [N-1:0]   i_op_a;
    logic [N-1:0]   i_op_b;
    logic           o_busy;
    logic           o_done;
    logic [2*N-1:0] o_product;
    logic           o_overflow;

    int checks;
    int errors;

    shift_add_mult_nb #(
        .N (N)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_product  (o_product),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Stimulus only: issue one start at a negedge in IDLE and wait for o_done.
    task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [2*N-1:0] prod, output logic ovf,
                           output int lat);
        i_op_a  = a;
        i_op_b  = b;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        prod = o_product;
        ovf  = o_overflow;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_op_a  = '0;
        i_op_b  = '0;
        repeat (3) @(negedge i_clk);
        checks += 4;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
        if (o_product !== 32'h0) begin errors++; $display("FAIL reset_product: got %h want 0", o_product); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        $display("test_reset: busy=%b done=%b product=%h ovf=%b", o_busy, o_done, o_product, o_overflow);
    endtask

    task automatic test_basic();
        int k;
        int busy_bad;
        i_op_a  = 16'd3;
        i_op_b  = 16'd5;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        k        = 1;
        busy_bad = 0;
        while (!o_done && k < 40) begin
            if (o_busy !== 1'b1) busy_bad++;
            @(negedge i_clk);
            k++;
        end
        checks += 5;
        if (k !== 17) begin errors++; $display("FAIL basic_latency: got %0d want 17", k); end
        if (busy_bad !== 0) begin errors++; $display("FAIL basic_busy_run: got %0d low cycles want 0", busy_bad); end
        if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b want 1", o_busy); end
        if (o_product !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h want 0000000f", o_product); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", o_overflow); end
        $display("test_basic: 3*5 latency=%0d product=%h ovf=%b", k, o_product, o_overflow);
        @(negedge i_clk);
        checks += 2;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", o_busy); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", o_done); end
    endtask

    task automatic test_ignore_start();
        int k;
        int n_done;
        int done_cyc;
        logic [2*N-1:0] prod;
        i_op_a  = 16'd7;
        i_op_b  = 16'd6;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        n_done   = 0;
        done_cyc = -1;
        prod     = '0;
        for (k = 1; k <= 40; k++) begin
            if (o_done) begin
                n_done++;
                done_cyc = k;
                prod     = o_product;
            end
            if (k == 5) begin
                i_start = 1'b1;
                i_op_a  = 16'd9;
                i_op_b  = 16'd9;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        checks += 3;
        if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
        if (done_cyc !== 17) begin errors++; $display("FAIL ignore_latency: got %0d want 17", done_cyc); end
        if (prod !== 32'd42) begin errors++; $display("FAIL ignore_product: got %h want 0000002a", prod); end
        $display("test_ignore_start: 7*6 dones=%0d at=%0d product=%h", n_done, done_cyc, prod);
    endtask

    task automatic test_corners();
        logic [2*N-1:0] prod;
        logic ovf;
        int lat;
        int hold_bad;

        do_mult(16'hFFFF, 16'hFFFF, prod, ovf, lat);
        checks += 3;
        if (lat !== 17) begin errors++; $display("FAIL ffff_latency: got %0d want 17", lat); end
        if (prod !== 32'hFFFE0001) begin errors++; $display("FAIL ffff_product: got %h want fffe0001", prod); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ffff_ovf: got %b want 1", ovf); end
        $display("test_corners: ffff*ffff product=%h ovf=%b", prod, ovf);

        // Result must stay put through idle cycles with changing operands.
        hold_bad = 0;
        repeat (6) begin
            @(negedge i_clk);
            i_op_a = 16'hA5A5;
            i_op_b = 16'h5A5A;
            if (o_product !== 32'hFFFE0001 || o_overflow !== 1'b1) hold_bad++;
        end
        checks += 1;
        if (hold_bad !== 0) begin errors++; $display("FAIL hold_product: got %0d changed cycles want 0", hold_bad); end

        do_mult(16'h1234, 16'h0000, prod, ovf, lat);
        checks += 2;
        if (prod !== 32'h0) begin errors++; $display("FAIL zero_b_product: got %h want 0", prod); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL zero_b_ovf: got %b want 0", ovf); end
        $display("test_corners: 1234*0000 product=%h ovf=%b", prod, ovf);
        @(negedge i_clk);

        do_mult(16'h0000, 16'hFFFF, prod, ovf, lat);
        checks += 2;
        if (prod !== 32'h0) begin errors++; $display("FAIL zero_a_product: got %h want 0", prod); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL zero_a_ovf: got %b want 0", ovf); end
        $display("test_corners: 0000*ffff product=%h ovf=%b", prod, ovf);
        @(negedge i_clk);

        do_mult(16'h0100, 16'h0100, prod, ovf, lat);
        checks += 2;
        if (prod !== 32'h00010000) begin errors++; $display("FAIL pow2_product: got %h want 00010000", prod); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL pow2_ovf: got %b want 1", ovf); end
        $display("test_corners: 0100*0100 product=%h ovf=%b", prod, ovf);
        @(negedge i_clk);
    endtask

    task automatic test_reset_abort();
        int k;
        int n_done;
        int busy_seen;
        logic [2*N-1:0] prod;
        logic ovf;
        int lat;

        i_op_a  = 16'h0055;
        i_op_b  = 16'h0003;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (k = 1; k < 8; k++) @(negedge i_clk);
        // Reset during RUN cycle 8, with a competing start request.
        i_rst_n = 1'b0;
        i_start = 1'b1;
        i_op_a  = 16'hFFFF;
        i_op_b  = 16'hFFFF;
        @(negedge i_clk);
        checks += 4;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", o_done); end
        if (o_product !== 32'h0) begin errors++; $display("FAIL abort_product: got %h want 0", o_product); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b want 0", o_overflow); end
        i_rst_n = 1'b1;
        i_start = 1'b0;
        n_done    = 0;
        busy_seen = 0;
        repeat (25) begin
            @(negedge i_clk);
            if (o_done) n_done++;
            if (o_busy) busy_seen++;
        end
        checks += 2;
        if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
        if (busy_seen !== 0) begin errors++; $display("FAIL abort_idle: got %0d busy cycles want 0", busy_seen); end

        do_mult(16'h0012, 16'h0034, prod, ovf, lat);
        checks += 3;
        if (lat !== 17) begin errors++; $display("FAIL abort_restart_latency: got %0d want 17", lat); end
        if (prod !== 32'h000003A8) begin errors++; $display("FAIL abort_restart_product: got %h want 000003a8", prod); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL abort_restart_ovf: got %b want 0", ovf); end
        $display("test_reset_abort: restart 0012*0034 product=%h ovf=%b", prod, ovf);
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp_prod;
        int k;

        a = 16'(($urandom));
        b = 16'(($urandom));
        exp_prod = 32'(a) * 32'(b);
        i_op_a  = a;
        i_op_b  = b;
        i_start = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            @(negedge i_clk);
            // Operands wander after capture; the result must not care.
            i_op_a = 16'($urandom);
            i_op_b = 16'($urandom);
            k = 1;
            while (!o_done && k < 40) begin
                @(negedge i_clk);
                k++;
            end
            checks += 3;
            if (k !== 17) begin errors++; $display("FAIL b2b_period it=%0d: got %0d want 17", it, k); end
            if (o_product !== exp_prod) begin errors++; $display("FAIL b2b_product it=%0d: got %h want %h", it, o_product, exp_prod); end
            if (o_overflow !== (|exp_prod[2*N-1:N])) begin errors++; $display("FAIL b2b_ovf it=%0d: got %b want %b", it, o_overflow, |exp_prod[2*N-1:N]); end
            $display("test_back_to_back it=%0d: %h*%h product=%h ovf=%b cycles=%0d", it, a, b, o_product, o_overflow, k);
            a = 16'($urandom);
            b = 16'($urandom);
            exp_prod = 32'(a) * 32'(b);
            i_op_a = a;
            i_op_b = b;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        repeat (20) @(negedge i_clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_op_a  = '0;
        i_op_b  = '0;
        @(negedge i_clk);
        test_reset();
        test_basic();
        test_ignore_start();
        test_corners();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_add_mult_nb.md
SHIFT_ADD_MULT_NB -- requirements
Module: shift_add_mult_nb

Interface
REQ-001 SHALL have parameter N, default 16: operand width in bits.
REQ-002 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port i_start, input, 1: request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port i_op_a, input, N: multiplicand, unsigned.
REQ-006 SHALL have port i_op_b, input, N: multiplier, unsigned.
REQ-007 SHALL have port o_busy, output, 1: high while a multiply is in progress (RUN or DONE).
REQ-008 SHALL have port o_done, output, 1: single-cycle pulse marking o_product valid.
REQ-009 SHALL have port o_product, output, 2N: unsigned product i_op_a*i_op_b.
REQ-010 SHALL have port o_overflow, output, 1: high when the product does not fit in N bits.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL perform every partial-product addition with exactly one instance of parallel_adder_nb, parameterized to width N with carry-in tied to 0, and no other adder.
REQ-013 In IDLE with i_start=1, SHALL capture i_op_a into the multiplicand register, load the low accumulator half with i_op_b, clear the high accumulator half and the iteration counter, and go to RUN.
REQ-014 In IDLE with i_start=0, SHALL hold all registers and o_product.
REQ-015 In each RUN cycle, SHALL form {c,s} = acc_hi + (acc_lo[0] ? multiplicand : 0) and load {acc_hi,acc_lo} <= {c,s,acc_lo} >> 1, so the adder carry-out enters bit 2N-1.
REQ-016 SHALL stay in RUN for exactly N cycles, counted by a ceil(log2(N+1))-bit counter, then go to DONE.
REQ-017 On entry to DONE, SHALL drive o_product = {acc_hi,acc_lo}, o_overflow = OR of o_product[2N-1:N], and o_done = 1 for that one cycle.
REQ-018 SHALL leave DONE for IDLE after one cycle, unconditionally.
REQ-019 SHALL assert o_done exactly N+1 cycles after the i_start cycle is accepted.
REQ-020 SHALL hold o_product and o_overflow stable from the o_done cycle until the next o_done or reset.
REQ-021 SHALL ignore i_start while in RUN or DONE; such a request SHALL be neither queued nor allowed to alter operands.
REQ-022 SHALL treat operand changes after the capture cycle as having no effect on the result in progress.
REQ-023 SHALL drive o_busy = 1 in RUN and DONE and 0 in IDLE.
REQ-024 SHALL accept i_start in the first IDLE cycle after DONE, giving back-to-back throughput of one result per N+2 cycles.
REQ-025 SHALL produce correct results when either operand is 0 or all ones, including a carry-out on the final iteration.

Reset
REQ-026 When i_rst_n=0 at a clock edge, SHALL go to IDLE and clear the accumulator, multiplicand, counter, o_product, o_overflow, o_done and o_busy to 0.
REQ-027 SHALL abort any operation on reset during RUN or DONE, emit no o_done for it, and take precedence over i_start.

Verification
REQ-028 N=16, start with a=3, b=5 -> o_done 17 cycles later; o_product=0x0000000F; o_overflow=0; o_busy high for cycles 1-17.
REQ-029 a=0xFFFF, b=0xFFFF -> o_product=0xFFFE0001 and o_overflow=1.
REQ-030 a=0x1234, b=0 then a=0, b=0xFFFF -> o_product=0 and o_overflow=0 each time; a=0x0100, b=0x0100 -> 0x00010000 with o_overflow=1.
REQ-031 start a=7, b=6, then pulse start with a=9, b=9 in cycle 5 -> result 42; second request ignored; no extra o_done.
REQ-032 i_rst_n low in cycle 8 of RUN -> next cycle all outputs 0 and state IDLE; no o_done; a new start then yields the correct product.
REQ-033 start held high continuously with random operands (1000 iterations) -> o_done every 18 cycles; each product matches a reference model.
